// File: rtl/pulse_gen8b.sv
// rtl/pulse_gen8b.sv - programmable burst pulse-train generator (IDLE/HIGH/LOW/FIN)
// Optional abort input enabled by defining PULSE_GEN8B_ABORT_EN.
module pulse_gen8b #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] half_period,
   input  logic [WIDTH-1:0] pulse_cnt,
`ifdef PULSE_GEN8B_ABORT_EN
   input  logic             abort,
`endif
   output logic             pulse,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] remaining
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_phase;
   logic [WIDTH-1:0] r_hp;
   logic [WIDTH-1:0] r_remaining;
   logic             r_pulse;
   logic             r_busy;
   logic             r_done;

   logic             w_abort;
   logic             w_phase_last;
   logic [WIDTH-1:0] w_hp_start;
   logic [WIDTH-1:0] w_phase_nxt;
   logic [WIDTH-1:0] w_hp_nxt;
   logic [WIDTH-1:0] w_rem_nxt;
   logic             w_pulse_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

`ifdef PULSE_GEN8B_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // A zero half-period would never let the phase counter expire, so it runs as 1.
   assign w_hp_start   = (half_period == '0) ? ONE : half_period;
   assign w_phase_last = (r_phase == ONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (pulse_cnt != '0) ? S_HIGH : S_FIN;
            end
         end
         S_HIGH: begin
            if (w_abort) begin
               w_next = S_FIN;
            end else if (w_phase_last) begin
               w_next = S_LOW;
            end
         end
         S_LOW: begin
            if (w_abort) begin
               w_next = S_FIN;
            end else if (w_phase_last) begin
               w_next = (r_remaining == ONE) ? S_FIN : S_HIGH;
            end
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the state being entered and then registered.
   always_comb begin
      w_pulse_nxt = (w_next == S_HIGH);
      w_busy_nxt  = (w_next == S_HIGH) || (w_next == S_LOW);
      w_done_nxt  = (w_next == S_FIN);
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_hp_nxt    = r_hp;
      w_rem_nxt   = r_remaining;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_hp_nxt    = w_hp_start;
               w_phase_nxt = w_hp_start;
               w_rem_nxt   = pulse_cnt;
            end
         end
         S_HIGH, S_LOW: begin
            if (!w_abort) begin
               if (w_phase_last) begin
                  w_phase_nxt = r_hp;
                  if ((r_state == S_LOW) && (r_remaining != '0)) begin
                     w_rem_nxt = r_remaining - ONE;
                  end
               end else begin
                  w_phase_nxt = r_phase - ONE;
               end
            end
         end
         default: begin
            w_phase_nxt = r_phase;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase     <= '0;
         r_hp        <= '0;
         r_remaining <= '0;
         r_pulse     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_phase     <= w_phase_nxt;
         r_hp        <= w_hp_nxt;
         r_remaining <= w_rem_nxt;
         r_pulse     <= w_pulse_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign pulse     = r_pulse;
   assign busy      = r_busy;
   assign done      = r_done;
   assign remaining = r_remaining;

endmodule

// File: tb/tb_pulse_gen8b.sv
// tb/tb_pulse_gen8b.sv - self-checking bench for pulse_gen8b with a cycle-accurate burst model
module tb_pulse_gen8b;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] half_period;
   logic [7:0] pulse_cnt;
`ifdef PULSE_GEN8B_ABORT_EN
   logic       abort;
`endif
   logic       pulse;
   logic       busy;
   logic       done;
   logic [7:0] remaining;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       p;
      logic       b;
      logic       d;
      logic [7:0] r;
   } exp_t;

   exp_t q[$];
   exp_t cur = '0;

   int   st_rise = 0;
   int   st_busy = 0;
   int   st_done = 0;
   logic prev_p  = 1'b0;

   pulse_gen8b #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .half_period (half_period),
      .pulse_cnt   (pulse_cnt),
`ifdef PULSE_GEN8B_ABORT_EN
      .abort       (abort),
`endif
      .pulse       (pulse),
      .busy        (busy),
      .done        (done),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Model: a burst is expanded into its full per-cycle output sequence at acceptance.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            q.delete();
            cur = '0;
         end else begin
            if (!cur.b && !cur.d && q.size() == 0 && start) begin
               int hp;
               int n;
               hp = (half_period == 8'd0) ? 1 : int'(half_period);
               n  = int'(pulse_cnt);
               for (int k = 0; k < n; k++) begin
                  for (int i = 0; i < hp; i++) q.push_back('{p:1'b1, b:1'b1, d:1'b0, r:8'(n - k)});
                  for (int i = 0; i < hp; i++) q.push_back('{p:1'b0, b:1'b1, d:1'b0, r:8'(n - k)});
               end
               q.push_back('{p:1'b0, b:1'b0, d:1'b1, r:8'd0});
            end
`ifdef PULSE_GEN8B_ABORT_EN
            else if (cur.b && abort) begin
               q.delete();
               q.push_back('{p:1'b0, b:1'b0, d:1'b1, r:cur.r});
            end
`endif
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{p:1'b0, b:1'b0, d:1'b0, r:cur.r};
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         n_assert++;
         if ({pulse, busy, done, remaining} !== cur) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t actual p=%0b b=%0b d=%0b rem=%0d required p=%0b b=%0b d=%0b rem=%0d",
                     $time, pulse, busy, done, remaining, cur.p, cur.b, cur.d, cur.r);
         end
         if (pulse === 1'b1 && prev_p !== 1'b1) st_rise++;
         prev_p = pulse;
         if (busy === 1'b1) st_busy++;
         if (done === 1'b1) st_done++;
      end
   end

   task automatic burst(input logic [7:0] hp, input logic [7:0] cnt, input int noise_at,
                        output int to_done, output int first_hi,
                        output int rises, output int busy_c, output int done_c);
      int r0, b0, d0, limit;
      r0 = st_rise; b0 = st_busy; d0 = st_done;
      limit = 2 * ((hp == 8'd0) ? 1 : int'(hp)) * int'(cnt) + 20;
      to_done  = 0;
      first_hi = 0;
      @(posedge clk); #2;
      start = 1'b1; half_period = hp; pulse_cnt = cnt;
      @(posedge clk); #2;
      start = 1'b0;
      forever begin
         @(negedge clk);
         to_done++;
         if (first_hi == 0 && pulse === 1'b1) first_hi = to_done;
         if (noise_at > 0 && to_done == noise_at) begin
            start = 1'b1; half_period = 8'd7; pulse_cnt = 8'd9;
         end
         if (noise_at > 0 && to_done == noise_at + 3) start = 1'b0;
         if (done === 1'b1) break;
         if (to_done > limit) begin
            chk("done_timeout", to_done, limit);
            break;
         end
      end
      repeat (2) @(negedge clk);
      #1;
      rises  = st_rise - r0;
      busy_c = st_busy - b0;
      done_c = st_done - d0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int td, fh, r, b, d, d0, b0, r0;
      rst = 1'b0; start = 1'b0; half_period = 8'd0; pulse_cnt = 8'd0;
`ifdef PULSE_GEN8B_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pulse", int'(pulse), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_remaining", int'(remaining), 0);
      @(posedge clk); #2;
      rst = 1'b1;

      burst(8'd3, 8'd4, 0, td, fh, r, b, d);
      chk("basic_first_rise", fh, 1);
      chk("basic_to_done", td, 25);
      chk("basic_rises", r, 4);
      chk("basic_busy_cycles", b, 24);
      chk("basic_done_cycles", d, 1);

      burst(8'd5, 8'd0, 0, td, fh, r, b, d);
      chk("zero_cnt_to_done", td, 1);
      chk("zero_cnt_rises", r, 0);
      chk("zero_cnt_busy", b, 0);
      chk("zero_cnt_done", d, 1);

      burst(8'd0, 8'd2, 0, td, fh, r, b, d);
      chk("hp0_to_done", td, 5);
      chk("hp0_rises", r, 2);
      chk("hp0_busy", b, 4);

      burst(8'd3, 8'd4, 5, td, fh, r, b, d);
      chk("ignored_start_to_done", td, 25);
      chk("ignored_start_rises", r, 4);
      chk("ignored_start_busy", b, 24);
      b0 = st_busy;
      repeat (10) @(negedge clk);
      #1;
      chk("idle_waits_for_start", st_busy - b0, 0);

      burst(8'd1, 8'd255, 0, td, fh, r, b, d);
      chk("max_to_done", td, 511);
      chk("max_rises", r, 255);
      chk("max_busy", b, 510);
      chk("max_remaining_end", int'(remaining), 0);

      @(posedge clk); #2;
      start = 1'b1; half_period = 8'd3; pulse_cnt = 8'd4;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      chk("pre_reset_pulse", int'(pulse), 1);
      chk("pre_reset_remaining", int'(remaining), 3);
      #1 rst = 1'b0;
      #1;
      chk("async_reset_pulse", int'(pulse), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_done", int'(done), 0);
      chk("async_reset_remaining", int'(remaining), 0);
      d0 = st_done;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      chk("no_done_after_reset", st_done - d0, 0);

`ifdef PULSE_GEN8B_ABORT_EN
      @(posedge clk); #2;
      start = 1'b1; half_period = 8'd2; pulse_cnt = 8'd10;
      @(posedge clk); #2;
      start = 1'b0;
      r0 = st_rise; d0 = st_done;
      repeat (13) @(negedge clk);
      #1;
      chk("abort_pre_pulse", int'(pulse), 1);
      chk("abort_pre_remaining", int'(remaining), 7);
      abort = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_pulse", int'(pulse), 0);
      chk("abort_done", int'(done), 1);
      chk("abort_remaining", int'(remaining), 7);
      abort = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("abort_done_once", st_done - d0, 1);
      chk("abort_rises", st_rise - r0, 4);
      chk("abort_remaining_held", int'(remaining), 7);
`else
      r0 = 0;
`endif

      repeat (3) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_gen8b.md
Name: pulse_gen8b

Overview:
Programmable pulse-train generator. It is the source end of the pulse-counting chain: it emits a burst of N square pulses with a programmable half-period, which the 8-bit pulse counters downstream count. It serves as an on-chip stimulus for rotational-speed measurement and as a known reference when calibrating the counter path.

Parameters:
WIDTH, 8, width of the pulse-count and half-period operands and of the remaining counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
start  input  1  request to begin a burst; sampled on the rising edge of clk.
half_period  input  WIDTH  clocks per high phase and per low phase; latched at the accepted start.
pulse_cnt  input  WIDTH  number of pulses in the burst; latched at the accepted start.
pulse  output  1  generated pulse train, registered.
busy  output  1  high while a burst is in progress.
done  output  1  single-cycle strobe marking the end of a burst.
remaining  output  WIDTH  pulses not yet completed, registered.

Behaviour:
- Reset: rst=0 forces state IDLE, pulse=0, busy=0, done=0, remaining=0, and clears the internal phase counter and latched operands, asynchronously. This also applies mid-burst: the burst is abandoned and no done strobe is issued.
- States: IDLE, HIGH, LOW, FIN.
- IDLE: busy=0, pulse=0. When start=1:
  - If pulse_cnt != 0: latch hp = max(half_period, 1), so half_period=0 is treated as 1. Load remaining=pulse_cnt and the phase counter with hp. Go to HIGH on the next edge; pulse rises on that same edge.
  - If pulse_cnt == 0: go to FIN with no pulse.
- HIGH: pulse=1 for exactly hp cycles. On the final cycle, reload the phase counter with hp and go to LOW.
- LOW: pulse=0 for exactly hp cycles. On the final cycle, decrement remaining.
  - If the new remaining value is 0, go to FIN.
  - Otherwise return to HIGH.
- FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- busy=1 in HIGH and LOW only.
- Timing:
  - Latency from the start edge to the first pulse rise is 1 cycle.
  - Period is 2*hp cycles.
  - The done strobe asserts on the cycle immediately after the last LOW cycle.
  - Total burst length is 2*hp*pulse_cnt cycles, plus 1 cycle for FIN.
- start while busy or in FIN is ignored; there is no queuing. start held high continuously restarts a new burst from IDLE each time FIN completes.
- Changing half_period or pulse_cnt mid-burst has no effect, because both are latched at the accepted start.
- Maximum burst is pulse_cnt=2^WIDTH-1 and half_period=2^WIDTH-1, with no wrap-around. remaining never underflows.
- All outputs come directly from registers; no combinational paths from inputs to outputs.

Optional Feature:
Macro: PULSE_GEN8B_ABORT_EN.
- Defined: adds input port abort (1 bit, after pulse_cnt). abort=1 in HIGH or LOW forces pulse=0 on the next edge and moves to FIN, so done pulses once. remaining holds its value at the abort, which lets the counter side compare counts. abort has priority over phase completion. abort in IDLE or FIN has no effect.
- Not defined: no abort port. A burst can only be ended by completion or by reset.

Test Plan:
1. Reset: rst=0 asserted asynchronously between clock edges mid-burst -> pulse=0, busy=0, done=0, remaining=0 immediately; no done after rst returns to 1.
2. Basic burst: half_period=3, pulse_cnt=4, start for 1 cycle -> 4 pulses, each 3 high / 3 low; busy for 24 cycles; remaining 4→3→2→1→0; done high for 1 cycle right after; downstream pulse counter reads 4.
3. Edge operands: pulse_cnt=0, half_period=5 -> no pulse, done 1 cycle after start, busy never asserted. half_period=0, pulse_cnt=2 -> behaves as hp=1, giving pulse pattern 1,0,1,0.
4. Ignored start: start asserted again during a burst with new values 7/9 -> current burst unaffected; after done, IDLE waits until start is asserted again.
5. Maximum: half_period=1, pulse_cnt=255 -> 255 pulses in 510 cycles, remaining ends at 0; an 8-bit counter downstream reads 255.
6. With PULSE_GEN8B_ABORT_EN: half_period=2, pulse_cnt=10, abort asserted in the HIGH phase of pulse 4 -> pulse=0 next cycle, done once, remaining=7.
